// File: rtl/data_sync_rx_if.sv
// ---------------------------------------------------------------------------
// data_sync_rx_if
//   Handshake / data bundle between a toggle-request source domain, the
//   data_sync_rx receiver and its downstream consumer.
//
//   Signals
//     UNSYNC_REQ    source -> rx   toggle-encoded request (asynchronous)
//     UNSYNC_BUS    source -> rx   data word, stable until the matching ACK toggle
//     ACK           rx -> source   toggle-encoded acknowledge
//     SYNC_BUS      rx -> consumer captured word
//     DATA_VALID    rx -> consumer SYNC_BUS holds an unaccepted word
//     ENABLE_PULSE  rx -> consumer one-cycle strobe when a new word becomes valid
//     DATA_READY    consumer -> rx consumer accepts SYNC_BUS this cycle
//     ERR           rx -> consumer sticky protocol-violation flag
//     ERR_CLR       consumer -> rx clears ERR
//
//   Modports
//     master : the environment (source + consumer)
//     slave  : the receiver
// ---------------------------------------------------------------------------
interface data_sync_rx_if #(
   parameter int BUS_WIDTH = 8
);
   logic                 UNSYNC_REQ;
   logic [BUS_WIDTH-1:0] UNSYNC_BUS;
   logic [BUS_WIDTH-1:0] SYNC_BUS;
   logic                 DATA_VALID;
   logic                 DATA_READY;
   logic                 ENABLE_PULSE;
   logic                 ACK;
   logic                 ERR;
   logic                 ERR_CLR;

   modport master (
      output UNSYNC_REQ,
      output UNSYNC_BUS,
      output DATA_READY,
      output ERR_CLR,
      input  SYNC_BUS,
      input  DATA_VALID,
      input  ENABLE_PULSE,
      input  ACK,
      input  ERR
   );

   modport slave (
      input  UNSYNC_REQ,
      input  UNSYNC_BUS,
      input  DATA_READY,
      input  ERR_CLR,
      output SYNC_BUS,
      output DATA_VALID,
      output ENABLE_PULSE,
      output ACK,
      output ERR
   );
endinterface

// File: rtl/data_sync_rx.sv
// ---------------------------------------------------------------------------
// data_sync_rx
//   Receiving half of a toggle-handshake clock-domain crossing. The request
//   toggle is synchronised through NUM_STAGES flops (legal 2..4), edge
//   detected, and used to capture the (quasi-static) source word. The word is
//   then held with a valid/ready handshake towards the consumer; on acceptance
//   the ACK toggle is returned to the source domain.
//
//   Ports
//     CLK   destination-domain clock, rising edge
//     RST   synchronous, active-low reset
//     bus   data_sync_rx_if.slave (see interface file for signal list);
//           the interface BUS_WIDTH must equal this module's BUS_WIDTH
//
//   Latency: a request toggle first sampled at edge k yields DATA_VALID,
//   ENABLE_PULSE and SYNC_BUS at edge k+NUM_STAGES.
// ---------------------------------------------------------------------------
module data_sync_rx #(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 8
) (
   input  logic           CLK,
   input  logic           RST,
   data_sync_rx_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   logic [NUM_STAGES-1:0] sync_reg;
   logic [NUM_STAGES-1:0] sync_next;
   logic                  req_sync;
   logic                  req_prev_reg;
   logic                  req_edge;

   state_t                state_reg;
   logic [BUS_WIDTH-1:0]  sync_bus_reg;
   logic                  data_valid_reg;
   logic                  enable_pulse_reg;
   logic                  ack_reg;
   logic                  err_reg;

   // Synchroniser chain: stage 0 samples the asynchronous request, every
   // following stage re-samples its predecessor.
   generate
      for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_next[gi] = bus.UNSYNC_REQ;
         end else begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= sync_next;
      end
   end

   assign req_sync = sync_reg[NUM_STAGES-1];
   // Both req_sync and req_prev reset to 0, so no edge is seen after reset
   // while the (also reset) source holds UNSYNC_REQ at 0.
   assign req_edge = req_sync ^ req_prev_reg;

   // Control FSM with all outputs registered.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         req_prev_reg     <= 1'b0;
         state_reg        <= IDLE;
         sync_bus_reg     <= '0;
         data_valid_reg   <= 1'b0;
         enable_pulse_reg <= 1'b0;
         ack_reg          <= 1'b0;
         err_reg          <= 1'b0;
      end else begin
         req_prev_reg     <= req_sync;
         enable_pulse_reg <= 1'b0;

         // A request arriving while a word is still held is a protocol
         // violation: flag it and drop the request. Setting beats clearing.
         if (state_reg == HOLD && req_edge) begin
            err_reg <= 1'b1;
         end else if (bus.ERR_CLR) begin
            err_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (req_edge) begin
                  sync_bus_reg     <= bus.UNSYNC_BUS;
                  data_valid_reg   <= 1'b1;
                  enable_pulse_reg <= 1'b1;
                  state_reg        <= HOLD;
               end
            end
            HOLD: begin
               // SYNC_BUS is intentionally left at the accepted word.
               if (bus.DATA_READY) begin
                  data_valid_reg <= 1'b0;
                  ack_reg        <= ~ack_reg;
                  state_reg      <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.SYNC_BUS     = sync_bus_reg;
   assign bus.DATA_VALID   = data_valid_reg;
   assign bus.ENABLE_PULSE = enable_pulse_reg;
   assign bus.ACK          = ack_reg;
   assign bus.ERR          = err_reg;

endmodule
